// File: rtl/vec_feeder_pkg.sv
// Shared types and default sizing for the vector-engine feeder.
package vec_feeder_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned IDX_W_DEF   = 10;
  localparam int unsigned TMO_CYC_DEF = 1048576;
  localparam int unsigned MAX_LEN     = 2**IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/vec_feeder_done_watch.sv
// Watches the engine done level while armed: stale-safe rising-edge detect,
// timeout detection and a saturating count of armed cycles.
module done_watch #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TMO_CYC = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              arm,
  input  logic              done,
  output logic              hit,
  output logic              tmo,
  output logic [DATA_W-1:0] cycles
);

  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  logic              done_q;
  logic              prev_q;
  logic              arm_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [DATA_W-1:0] cyc_q;
  logic [DATA_W-1:0] cyc_d;
  logic              entry_s;

  // The first armed cycle treats the previous done sample as high, so a level
  // left over from the prior job can never look like a fresh rising edge.
  assign entry_s = arm & ~arm_q;
  assign hit     = arm & done_q & ~prev_q & ~entry_s;
  assign tmo     = arm & ~hit & (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
  assign cyc_d   = (&cyc_q) ? cyc_q : cyc_q + DATA_W'(1);
  assign cycles  = cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      prev_q    <= 1'b0;
      arm_q     <= 1'b0;
      tmo_cnt_q <= '0;
      cyc_q     <= '0;
    end else begin
      done_q <= done;
      prev_q <= done_q;
      arm_q  <= arm;
      if (clr) begin
        tmo_cnt_q <= '0;
        cyc_q     <= '0;
      end else if (arm) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        cyc_q     <= cyc_d;
      end else begin
        tmo_cnt_q <= tmo_cnt_q;
        cyc_q     <= cyc_q;
      end
    end
  end

endmodule

// File: rtl/vec_feeder.sv
// Host-side feeder: takes a job length and an (a,b) stream, writes the engine
// memory, publishes n, then waits for done and reports cycles/errors.
module vec_feeder
  import vec_feeder_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  output logic              acc_we,
  output logic [IDX_W-1:0]  acc_index,
  output logic [DATA_W-1:0] acc_a_data,
  output logic [DATA_W-1:0] acc_b_data,
  output logic [DATA_W-1:0] acc_n,
  input  logic              acc_done,
  output logic              busy,
  output logic              finish,
  output logic              err_len,
  output logic              err_timeout,
  output logic [DATA_W-1:0] cycles
);

  localparam logic [DATA_W:0] MAX_LEN_C = {{DATA_W{1'b0}}, 1'b1} << IDX_W;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              acc_we_q;
  logic [IDX_W-1:0]  acc_index_q;
  logic [DATA_W-1:0] acc_a_q;
  logic [DATA_W-1:0] acc_b_q;
  logic [DATA_W-1:0] acc_n_q;
  logic              finish_q;
  logic              err_len_q;
  logic              err_tmo_q;

  logic cmd_acc_s;
  logic last_s;
  logic hit_s;
  logic tmo_s;

  assign cmd_ready = (state_q == IDLE);
  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign cmd_acc_s = cmd_valid & cmd_ready;
  assign last_s    = (DATA_W'(idx_q) == acc_n_q - DATA_W'(1));

  assign acc_we      = acc_we_q;
  assign acc_index   = acc_index_q;
  assign acc_a_data  = acc_a_q;
  assign acc_b_data  = acc_b_q;
  assign acc_n       = acc_n_q;
  assign finish      = finish_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;

  done_watch #(
    .DATA_W  (DATA_W),
    .TMO_CYC (TMO_CYC)
  ) u_done_watch (
    .clk    (clk),
    .rst    (rst),
    .clr    (cmd_acc_s),
    .arm    (state_q == WAIT),
    .done   (acc_done),
    .hit    (hit_s),
    .tmo    (tmo_s),
    .cycles (cycles)
  );

  // Job FSM with registered write port, status and completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_we_q    <= 1'b0;
      acc_index_q <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      acc_n_q     <= '0;
      finish_q    <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      acc_we_q <= 1'b0;
      finish_q <= (state_q == FIN);
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            acc_n_q   <= cmd_len;
            idx_q     <= '0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            if (cmd_len == '0) begin
              state_q <= FIN;
            end else if ({1'b0, cmd_len} > MAX_LEN_C) begin
              err_len_q <= 1'b1;
              state_q   <= FIN;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            acc_we_q    <= 1'b1;
            acc_index_q <= idx_q;
            acc_a_q     <= s_a;
            acc_b_q     <= s_b;
            idx_q       <= idx_q + IDX_W'(1);
            if (last_s) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (hit_s) begin
            state_q <= FIN;
          end else if (tmo_s) begin
            err_tmo_q <= 1'b1;
            state_q   <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_feeder.sv
// Directed self-checking bench for vec_feeder (TMO_CYC shortened to 16).
module tb_vec_feeder;
  import vec_feeder_pkg::*;

  localparam int DW = 32;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_a = '0;
  logic [DW-1:0] s_b = '0;
  logic          acc_we;
  logic [IW-1:0] acc_index;
  logic [DW-1:0] acc_a_data;
  logic [DW-1:0] acc_b_data;
  logic [DW-1:0] acc_n;
  logic          acc_done = 1'b0;
  logic          busy;
  logic          finish;
  logic          err_len;
  logic          err_timeout;
  logic [DW-1:0] cycles;

  int errors = 0;
  int checks = 0;
  int fin_cnt = 0;
  int sready_cnt = 0;
  int q_idx[$];
  int q_a[$];
  int q_b[$];

  vec_feeder #(.DATA_W(DW), .IDX_W(IW), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .acc_we(acc_we), .acc_index(acc_index), .acc_a_data(acc_a_data),
    .acc_b_data(acc_b_data), .acc_n(acc_n), .acc_done(acc_done), .busy(busy),
    .finish(finish), .err_len(err_len), .err_timeout(err_timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (acc_we) begin
      q_idx.push_back(int'(acc_index));
      q_a.push_back(int'(acc_a_data));
      q_b.push_back(int'(acc_b_data));
    end
    if (finish) fin_cnt++;
    if (s_ready) sready_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_log();
    q_idx.delete(); q_a.delete(); q_b.delete();
    fin_cnt = 0;
    sready_cnt = 0;
  endtask

  task automatic send_cmd(input int len);
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); errors++;
    end
    cmd_valid = 1'b1;
    cmd_len   = DW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Ends on the negedge after the final beat (first WAIT cycle for a full job).
  task automatic drive_beats(input int n, input int gap, input int a0, input int b0);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_a = DW'(a0 + i); s_b = DW'(b0 + i);
      @(negedge clk);
      if (gap != 0 && i < n - 1) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int want);
    int n = 0;
    while (finish !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != want) begin
      $display("FAIL %s_finish_latency: got %0d want %0d", name, n, want); errors++;
    end
  endtask

  task automatic check_writes(input string name, input int n, input int a0, input int b0);
    checks++;
    if (q_idx.size() != n) begin
      $display("FAIL %s_write_count: got %0d want %0d", name, q_idx.size(), n); errors++;
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (q_idx[i] != i || q_a[i] != a0 + i || q_b[i] != b0 + i) begin
          $display("FAIL %s_write%0d: got idx=%0d a=%0d b=%0d want idx=%0d a=%0d b=%0d",
                   name, i, q_idx[i], q_a[i], q_b[i], i, a0 + i, b0 + i);
          errors++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, s_ready, busy, acc_we, finish, err_len, err_timeout} !== 7'b1000000) begin
      $display("FAIL reset_flags: got %b want 1000000",
               {cmd_ready, s_ready, busy, acc_we, finish, err_len, err_timeout});
      errors++;
    end
    checks++;
    if (acc_n !== '0 || cycles !== '0 || acc_index !== '0 || acc_a_data !== '0 || acc_b_data !== '0) begin
      $display("FAIL reset_data: got n=%0d cyc=%0d idx=%0d want 0", acc_n, cycles, acc_index);
      errors++;
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_log();
    send_cmd(4);
    drive_beats(4, 0, 1, 5);
    checks++;
    if (s_ready !== 1'b0) begin
      $display("FAIL t1_sready_drop: got %b want 0", s_ready); errors++;
    end
    repeat (8) @(negedge clk);
    acc_done = 1'b1;
    wait_finish("t1", 3);
    checks++;
    if (cycles !== 32'd10 || acc_n !== 32'd4) begin
      $display("FAIL t1_cycles_n: got cycles=%0d n=%0d want 10 4", cycles, acc_n); errors++;
    end
    @(negedge clk);
    checks++;
    if (fin_cnt != 1 || busy !== 1'b0 || err_len !== 1'b0 || err_timeout !== 1'b0) begin
      $display("FAIL t1_finish_once: got fin=%0d busy=%b el=%b et=%b want 1 0 0 0",
               fin_cnt, busy, err_len, err_timeout);
      errors++;
    end
    check_writes("t1", 4, 1, 5);
  endtask

  task automatic test_stale_done();
    clear_log();
    send_cmd(2);
    drive_beats(2, 0, 30, 40);
    @(negedge clk);
    acc_done = 1'b0;
    repeat (3) @(negedge clk);
    acc_done = 1'b1;
    checks++;
    if (fin_cnt != 0 || busy !== 1'b1) begin
      $display("FAIL t5_no_early_finish: got fin=%0d busy=%b want 0 1", fin_cnt, busy); errors++;
    end
    wait_finish("t5", 3);
    checks++;
    if (cycles !== 32'd6) begin
      $display("FAIL t5_cycles: got %0d want 6", cycles); errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_bubbles();
    clear_log();
    acc_done = 1'b0;
    send_cmd(3);
    drive_beats(3, 1, 10, 20);
    acc_done = 1'b1;
    wait_finish("t2", 3);
    checks++;
    if (cycles !== 32'd2) begin
      $display("FAIL t2_cycles: got %0d want 2", cycles); errors++;
    end
    @(negedge clk);
    check_writes("t2", 3, 10, 20);
    acc_done = 1'b0;
  endtask

  task automatic test_zero_len();
    clear_log();
    send_cmd(0);
    checks++;
    if (finish !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL t3_fin_state: got finish=%b busy=%b want 0 1", finish, busy); errors++;
    end
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || err_len !== 1'b0 || err_timeout !== 1'b0 || acc_n !== '0 || q_idx.size() != 0) begin
      $display("FAIL t3_zero_len: got finish=%b el=%b et=%b n=%0d writes=%0d want 1 0 0 0 0",
               finish, err_len, err_timeout, acc_n, q_idx.size());
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_too_long();
    clear_log();
    send_cmd(MAX_LEN + 1);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || err_len !== 1'b1 || acc_n !== 32'd1025) begin
      $display("FAIL t4_err_len: got finish=%b el=%b n=%0d want 1 1 1025", finish, err_len, acc_n);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (sready_cnt != 0 || q_idx.size() != 0 || err_len !== 1'b1) begin
      $display("FAIL t4_no_load: got sready=%0d writes=%0d el=%b want 0 0 1",
               sready_cnt, q_idx.size(), err_len);
      errors++;
    end
  endtask

  task automatic test_timeout();
    clear_log();
    acc_done = 1'b0;
    send_cmd(2);
    drive_beats(2, 0, 7, 8);
    wait_finish("t6", 17);
    checks++;
    if (err_timeout !== 1'b1 || cycles !== 32'd16 || err_len !== 1'b0) begin
      $display("FAIL t6_timeout: got et=%b cycles=%0d el=%b want 1 16 0", err_timeout, cycles, err_len);
      errors++;
    end
    @(negedge clk);
    send_cmd(1);
    checks++;
    if (err_timeout !== 1'b0 || cycles !== '0) begin
      $display("FAIL t6_clear: got et=%b cycles=%0d want 0 0", err_timeout, cycles); errors++;
    end
    drive_beats(1, 0, 3, 4);
    acc_done = 1'b1;
    wait_finish("t6b", 3);
    @(negedge clk);
    acc_done = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    clear_log();
    send_cmd(4);
    drive_beats(2, 0, 50, 60);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, s_ready, busy, acc_we, finish} !== 5'b10000 || acc_n !== '0 || acc_index !== '0 ||
        acc_a_data !== '0 || acc_b_data !== '0) begin
      $display("FAIL t7_async_reset: got flags=%b n=%0d idx=%0d want 10000 0 0",
               {cmd_ready, s_ready, busy, acc_we, finish}, acc_n, acc_index);
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_log();
    send_cmd(2);
    drive_beats(2, 0, 70, 80);
    acc_done = 1'b1;
    wait_finish("t7", 3);
    @(negedge clk);
    check_writes("t7", 2, 70, 80);
    checks++;
    if (fin_cnt != 1) begin
      $display("FAIL t7_finish_count: got %0d want 1", fin_cnt); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_done();
    test_bubbles();
    test_zero_len();
    test_too_long();
    test_timeout();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
